tw_cmd_queue: RTL and testbench

TW_CMD_QUEUE -- requirements
Module: tw_cmd_queue

---
 rtl/tw_pkg.sv | 25 ++
 rtl/tw_cmd_fifo.sv | 75 +++++++
 rtl/tw_cmd_queue.sv | 175 +++++++++++++++++
 tb/tb_tw_cmd_queue.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tw_pkg.sv
// ============================================================================
// Module : tw_pkg
// Shared defaults and FSM state encoding for the three-wire command queue.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package tw_pkg;

    localparam int unsigned TW_ADDR_BITS      = 9;
    localparam int unsigned TW_DATA_BITS      = 16;
    localparam int unsigned TW_DEPTH          = 8;
    localparam int unsigned TW_TIMEOUT_CYCLES = 255;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RESPOND   = 3'd4
    } tw_state_e;

endpackage : tw_pkg

`default_nettype wire

// File: rtl/tw_cmd_fifo.sv
// ============================================================================
// Module : tw_cmd_fifo
// Synchronous command FIFO with occupancy output; pushes while full are dropped.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tw_cmd_fifo
    import tw_pkg::*;
#(
    parameter int WIDTH = 1 + TW_ADDR_BITS + TW_DATA_BITS,
    parameter int DEPTH = TW_DEPTH
) (
    input  logic                   in_clk,
    input  logic                   in_rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    output logic [WIDTH-1:0]       rd_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;

    logic w_push_ok;
    logic w_pop_ok;

    assign full_o    = (level_q == FULL_LVL);
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    assign w_push_ok = push_i && !full_o;
    assign w_pop_ok  = pop_i && !empty_o;

    // Storage carries no reset; validity is tracked by the level alone.
    always_ff @(posedge in_clk) begin
        if (w_push_ok) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (w_push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule : tw_cmd_fifo

`default_nettype wire

// File: rtl/tw_cmd_queue.sv
// ============================================================================
// Module : tw_cmd_queue
// Queues host register commands and sequences them onto a three-wire master.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tw_cmd_queue
    import tw_pkg::*;
#(
    parameter int ADDR_BITS      = TW_ADDR_BITS,
    parameter int DATA_BITS      = TW_DATA_BITS,
    parameter int DEPTH          = TW_DEPTH,
    parameter int TIMEOUT_CYCLES = TW_TIMEOUT_CYCLES
) (
    input  logic                   in_clk,
    input  logic                   in_rst,

    input  logic                   in_cmd_valid,
    output logic                   out_cmd_ready,
    input  logic                   in_cmd_r_w,
    input  logic [ADDR_BITS-1:0]   in_cmd_addr,
    input  logic [DATA_BITS-1:0]   in_cmd_wr_data,

    output logic                   out_tw_start,
    output logic                   out_tw_r_w,
    output logic [ADDR_BITS-1:0]   out_tw_addr,
    output logic [DATA_BITS-1:0]   out_tw_wr_data,
    input  logic                   in_tw_busy,
    input  logic [DATA_BITS-1:0]   in_tw_rd_data,

    output logic                   out_rsp_valid,
    input  logic                   in_rsp_ready,
    output logic [ADDR_BITS-1:0]   out_rsp_addr,
    output logic [DATA_BITS-1:0]   out_rsp_data,
    output logic                   out_rsp_timeout,

    output logic [$clog2(DEPTH):0] out_fifo_level,
    output logic                   out_idle
);

    localparam int CMD_W = 1 + ADDR_BITS + DATA_BITS;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    tw_state_e            state_q;
    logic                 tw_start_q;
    logic                 tw_r_w_q;
    logic [ADDR_BITS-1:0] tw_addr_q;
    logic [DATA_BITS-1:0] tw_wr_data_q;
    logic                 rsp_valid_q;
    logic [ADDR_BITS-1:0] rsp_addr_q;
    logic [DATA_BITS-1:0] rsp_data_q;
    logic                 rsp_timeout_q;
    logic [CNT_W-1:0]     cnt_q;

    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [CMD_W-1:0]     w_head;
    logic                 w_pop;
    logic [CNT_W-1:0]     w_cnt_inc;
    logic                 w_cnt_hit;

    assign w_pop     = (state_q == ST_IDLE) && !w_fifo_empty;
    assign w_cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    // True on the edge where the counter would reach TIMEOUT_CYCLES.
    assign w_cnt_hit = (cnt_q >= CNT_LAST);

    tw_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .in_clk    (in_clk),
        .in_rst    (in_rst),
        .push_i    (in_cmd_valid),
        .pop_i     (w_pop),
        .wr_data_i ({in_cmd_r_w, in_cmd_addr, in_cmd_wr_data}),
        .rd_data_o (w_head),
        .full_o    (w_fifo_full),
        .empty_o   (w_fifo_empty),
        .level_o   (out_fifo_level)
    );

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q       <= ST_IDLE;
            tw_start_q    <= 1'b0;
            tw_r_w_q      <= 1'b0;
            tw_addr_q     <= '0;
            tw_wr_data_q  <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_addr_q    <= '0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            tw_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!w_fifo_empty) begin
                        {tw_r_w_q, tw_addr_q, tw_wr_data_q} <= w_head;
                        tw_start_q <= 1'b1;
                        state_q    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (in_tw_busy) begin
                        cnt_q   <= '0;
                        state_q <= ST_WAIT_DONE;
                    end else if (w_cnt_hit) begin
                        cnt_q         <= w_cnt_inc;
                        rsp_valid_q   <= 1'b1;
                        rsp_addr_q    <= tw_addr_q;
                        rsp_data_q    <= '0;
                        rsp_timeout_q <= 1'b1;
                        state_q       <= ST_RESPOND;
                    end else begin
                        cnt_q <= w_cnt_inc;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!in_tw_busy) begin
                        rsp_data_q    <= in_tw_rd_data;
                        rsp_timeout_q <= 1'b0;
                        // Only reads report back; a clean write just retires.
                        if (!tw_r_w_q) begin
                            rsp_valid_q <= 1'b1;
                            rsp_addr_q  <= tw_addr_q;
                            state_q     <= ST_RESPOND;
                        end else begin
                            state_q     <= ST_IDLE;
                        end
                    end else if (w_cnt_hit) begin
                        cnt_q         <= w_cnt_inc;
                        rsp_valid_q   <= 1'b1;
                        rsp_addr_q    <= tw_addr_q;
                        rsp_data_q    <= '0;
                        rsp_timeout_q <= 1'b1;
                        state_q       <= ST_RESPOND;
                    end else begin
                        cnt_q <= w_cnt_inc;
                    end
                end
                ST_RESPOND: begin
                    if (in_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_cmd_ready   = !w_fifo_full;
    assign out_tw_start    = tw_start_q;
    assign out_tw_r_w      = tw_r_w_q;
    assign out_tw_addr     = tw_addr_q;
    assign out_tw_wr_data  = tw_wr_data_q;
    assign out_rsp_valid   = rsp_valid_q;
    assign out_rsp_addr    = rsp_addr_q;
    assign out_rsp_data    = rsp_data_q;
    assign out_rsp_timeout = rsp_timeout_q;
    assign out_idle        = w_fifo_empty && (state_q == ST_IDLE);

endmodule : tw_cmd_queue

`default_nettype wire

// File: tb/tb_tw_cmd_queue.sv
// ============================================================================
// Module : tb_tw_cmd_queue
// Directed self-checking bench for tw_cmd_queue with hand-computed expectations.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_tw_cmd_queue;

    logic        in_clk = 1'b0;
    logic        in_rst;
    logic        in_cmd_valid;
    logic        out_cmd_ready;
    logic        in_cmd_r_w;
    logic [8:0]  in_cmd_addr;
    logic [15:0] in_cmd_wr_data;
    logic        out_tw_start;
    logic        out_tw_r_w;
    logic [8:0]  out_tw_addr;
    logic [15:0] out_tw_wr_data;
    logic        in_tw_busy;
    logic [15:0] in_tw_rd_data;
    logic        out_rsp_valid;
    logic        in_rsp_ready;
    logic [8:0]  out_rsp_addr;
    logic [15:0] out_rsp_data;
    logic        out_rsp_timeout;
    logic [3:0]  out_fifo_level;
    logic        out_idle;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc       = 0;
    int start_cnt = 0;
    int start_cyc = 0;

    always #5 in_clk = ~in_clk;

    tw_cmd_queue u_dut (
        .in_clk          (in_clk),
        .in_rst          (in_rst),
        .in_cmd_valid    (in_cmd_valid),
        .out_cmd_ready   (out_cmd_ready),
        .in_cmd_r_w      (in_cmd_r_w),
        .in_cmd_addr     (in_cmd_addr),
        .in_cmd_wr_data  (in_cmd_wr_data),
        .out_tw_start    (out_tw_start),
        .out_tw_r_w      (out_tw_r_w),
        .out_tw_addr     (out_tw_addr),
        .out_tw_wr_data  (out_tw_wr_data),
        .in_tw_busy      (in_tw_busy),
        .in_tw_rd_data   (in_tw_rd_data),
        .out_rsp_valid   (out_rsp_valid),
        .in_rsp_ready    (in_rsp_ready),
        .out_rsp_addr    (out_rsp_addr),
        .out_rsp_data    (out_rsp_data),
        .out_rsp_timeout (out_rsp_timeout),
        .out_fifo_level  (out_fifo_level),
        .out_idle        (out_idle)
    );

    // Start-pulse monitor, sampled on the falling edge.
    always @(negedge in_clk) begin
        cyc <= cyc + 1;
        if (out_tw_start) begin
            start_cnt <= start_cnt + 1;
            start_cyc <= cyc + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge in_clk);
        #1;
    endtask

    task automatic push(input logic rw, input logic [8:0] a, input logic [15:0] d);
        in_cmd_valid   = 1'b1;
        in_cmd_r_w     = rw;
        in_cmd_addr    = a;
        in_cmd_wr_data = d;
        tick();
        in_cmd_valid   = 1'b0;
    endtask

    task automatic wait_start(input string tag, input int budget);
        int s0;
        int n;
        s0 = start_cnt;
        n  = 0;
        while (start_cnt == s0 && n < budget) begin
            tick();
            n++;
        end
        check_val(tag, 32'(start_cnt != s0), 32'd1);
    endtask

    initial begin
        int s0;
        int bad;
        int rsp_seen;
        int got;
        int budget;

        in_rst         = 1'b1;
        in_cmd_valid   = 1'b0;
        in_cmd_r_w     = 1'b0;
        in_cmd_addr    = '0;
        in_cmd_wr_data = '0;
        in_tw_busy     = 1'b0;
        in_tw_rd_data  = '0;
        in_rsp_ready   = 1'b0;
        repeat (3) tick();
        in_rst = 1'b0;
        tick();

        // Reset state
        check_val("rst_ready", 32'(out_cmd_ready), 32'd1);
        check_val("rst_idle",  32'(out_idle),      32'd1);
        check_val("rst_start", 32'(out_tw_start),  32'd0);
        check_val("rst_valid", 32'(out_rsp_valid), 32'd0);
        check_val("rst_level", 32'(out_fifo_level), 32'd0);

        // Write 0x1A5/0xBEEF, busy pulse of 70 cycles
        s0 = start_cnt;
        push(1'b1, 9'h1A5, 16'hBEEF);
        check_val("wr_level_after_push", 32'(out_fifo_level), 32'd1);
        check_val("wr_no_early_start",   32'(out_tw_start),   32'd0);
        tick();
        check_val("wr_start",  32'(out_tw_start),   32'd1);
        check_val("wr_addr",   32'(out_tw_addr),    32'h1A5);
        check_val("wr_data",   32'(out_tw_wr_data), 32'hBEEF);
        check_val("wr_rw",     32'(out_tw_r_w),     32'd1);
        check_val("wr_level0", 32'(out_fifo_level), 32'd0);
        bad = 0;
        rsp_seen = 0;
        for (int k = 1; k <= 100; k++) begin
            in_tw_busy = (k >= 3 && k < 73);
            tick();
            if (!out_idle && (out_tw_addr !== 9'h1A5 || out_tw_wr_data !== 16'hBEEF || out_tw_r_w !== 1'b1))
                bad++;
            if (out_rsp_valid) rsp_seen++;
        end
        in_tw_busy = 1'b0;
        check_val("wr_single_start", 32'(start_cnt - s0), 32'd1);
        check_val("wr_stable",       32'(bad),            32'd0);
        check_val("wr_no_rsp",       32'(rsp_seen),       32'd0);
        check_val("wr_idle",         32'(out_idle),       32'd1);

        // Read 0x003 returning 0x1234, host stalls the response
        push(1'b0, 9'h003, 16'h0000);
        wait_start("rd_start", 5);
        in_tw_busy = 1'b1;
        repeat (4) tick();
        in_tw_busy    = 1'b0;
        in_tw_rd_data = 16'h1234;
        tick();
        in_tw_rd_data = 16'h0000;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (out_rsp_valid !== 1'b1 || out_rsp_addr !== 9'h003 ||
                out_rsp_data !== 16'h1234 || out_rsp_timeout !== 1'b0)
                bad++;
            tick();
        end
        check_val("rd_rsp_valid",   32'(out_rsp_valid),   32'd1);
        check_val("rd_rsp_addr",    32'(out_rsp_addr),    32'h003);
        check_val("rd_rsp_data",    32'(out_rsp_data),    32'h1234);
        check_val("rd_rsp_timeout", 32'(out_rsp_timeout), 32'd0);
        check_val("rd_rsp_hold",    32'(bad),             32'd0);

        // Nine pushes while parked in RESPOND: eight land, ninth refused
        for (int i = 0; i < 9; i++) begin
            check_val($sformatf("fill_ready_%0d", i), 32'(out_cmd_ready), (i < 8) ? 32'd1 : 32'd0);
            if (i == 8) check_val("fill_level_full", 32'(out_fifo_level), 32'd8);
            in_cmd_valid   = 1'b1;
            in_cmd_r_w     = 1'(i);
            in_cmd_addr    = 9'(9'h100 + i);
            in_cmd_wr_data = 16'(i);
            tick();
        end
        in_cmd_valid = 1'b0;
        check_val("fill_level_unchanged", 32'(out_fifo_level), 32'd8);
        check_val("fill_rsp_still_held",  32'(out_rsp_valid),  32'd1);
        check_val("fill_rsp_data_held",   32'(out_rsp_data),   32'h1234);
        in_rsp_ready = 1'b1;
        tick();
        check_val("rd_rsp_released", 32'(out_rsp_valid), 32'd0);

        // Each queued command times out in WAIT_BUSY
        got = 0;
        budget = 8 * 300;
        while (got < 8 && budget > 0) begin
            tick();
            budget--;
            if (out_rsp_valid) begin
                check_val($sformatf("to_addr_%0d", got),    32'(out_rsp_addr),    32'(9'h100 + got));
                check_val($sformatf("to_data_%0d", got),    32'(out_rsp_data),    32'd0);
                check_val($sformatf("to_flag_%0d", got),    32'(out_rsp_timeout), 32'd1);
                check_val($sformatf("to_latency_%0d", got), 32'(cyc - start_cyc), 32'd256);
                got++;
            end
        end
        check_val("to_rsp_count", 32'(got), 32'd8);
        repeat (3) tick();
        check_val("to_idle",  32'(out_idle),       32'd1);
        check_val("to_level", 32'(out_fifo_level), 32'd0);

        // Busy rises and sticks: timeout from WAIT_DONE, then next command issues
        push(1'b0, 9'h055, 16'h0000);
        wait_start("wd_start", 5);
        in_tw_busy = 1'b1;
        push(1'b1, 9'h066, 16'h0666);
        budget = 400;
        while (!out_rsp_valid && budget > 0) begin
            tick();
            budget--;
        end
        check_val("wd_rsp_valid",   32'(out_rsp_valid),   32'd1);
        check_val("wd_rsp_addr",    32'(out_rsp_addr),    32'h055);
        check_val("wd_rsp_timeout", 32'(out_rsp_timeout), 32'd1);
        check_val("wd_rsp_data",    32'(out_rsp_data),    32'd0);
        check_val("wd_latency",     32'(cyc - start_cyc), 32'd257);
        tick();
        wait_start("wd_next_start", 10);
        check_val("wd_next_addr", 32'(out_tw_addr),    32'h066);
        check_val("wd_next_rw",   32'(out_tw_r_w),     32'd1);
        check_val("wd_next_data", 32'(out_tw_wr_data), 32'h0666);

        // Reset with a command in WAIT_DONE and three queued
        repeat (3) tick();
        push(1'b0, 9'h070, 16'h0000);
        push(1'b1, 9'h071, 16'h0001);
        push(1'b0, 9'h072, 16'h0002);
        check_val("mr_level3", 32'(out_fifo_level), 32'd3);
        in_rst = 1'b1;
        #1;
        check_val("mr_start",   32'(out_tw_start),    32'd0);
        check_val("mr_rw",      32'(out_tw_r_w),      32'd0);
        check_val("mr_addr",    32'(out_tw_addr),     32'd0);
        check_val("mr_wdata",   32'(out_tw_wr_data),  32'd0);
        check_val("mr_valid",   32'(out_rsp_valid),   32'd0);
        check_val("mr_raddr",   32'(out_rsp_addr),    32'd0);
        check_val("mr_rdata",   32'(out_rsp_data),    32'd0);
        check_val("mr_timeout", 32'(out_rsp_timeout), 32'd0);
        check_val("mr_level",   32'(out_fifo_level),  32'd0);
        check_val("mr_ready",   32'(out_cmd_ready),   32'd1);
        in_tw_busy = 1'b0;
        tick();
        in_rst = 1'b0;
        s0 = start_cnt;
        rsp_seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (out_rsp_valid) rsp_seen++;
        end
        check_val("mr_no_start_after", 32'(start_cnt - s0), 32'd0);
        check_val("mr_no_rsp_after",   32'(rsp_seen),       32'd0);
        check_val("mr_idle_after",     32'(out_idle),       32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_tw_cmd_queue

`default_nettype wire
